ysyx_25040109_mem_arb: RTL and testbench
========================================

// Module: ysyx_25040109_mem_arb
// PURPOSE
//   Memory-side neighbour of the CPU core. Merges the CPU fetch channel (imem_*) and
//   load/store channel (dmem_*) onto one single-port backend request/response bus.
//   Serves one request at a time, under fixed priority. Generates byte strobes and
//   returns per-channel valid/ready pulses. Guards against a hung backend with a timeout.
// PARAMETERS
//   TIMEOUT     256    cycles in WAIT before an access is aborted (>=2)
//   ERR_RDATA   32'hDEADBEEF  read data returned on timeout or misaligned access
//   LFSR_SEED   8'hA5  nonzero seed of the delay LFSR (used only with the _EN macro)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset, asynchronous, active-low
//   imem_addr    in   32  fetch address
//   imem_ren     in   1   fetch request (level)
//   imem_rdata   out  32  fetch data, valid with imem_rvalid
//   imem_rvalid  out  1   one-cycle fetch response pulse
//   dmem_raddr   in   32  load address
//   dmem_ren     in   1   load request (level)
//   dmem_rdata   out  32  load word (aligned word; LSU extracts bytes)
//   dmem_rvalid  out  1   one-cycle load response pulse
//   dmem_waddr   in   32  store address
//   dmem_wdata   in   32  store data, LSB-justified
//   dmem_wlen    in   3   store length in bytes: 1, 2 or 4
//   dmem_wen     in   1   store request (level)
//   dmem_wready  out  1   one-cycle store completion pulse
//   mem_req      out  1   backend request valid
//   mem_we       out  1   backend write
//   mem_addr     out  32  backend address, bits[1:0] forced to 0
//   mem_wdata    out  32  store data shifted left by 8*addr[1:0]
//   mem_wstrb    out  4   byte strobes
//   mem_ready    in   1   backend accepts request (handshake when mem_req&&mem_ready)
//   mem_rvalid   in   1   backend response (read data or write ack), one cycle
//   mem_rdata    in   32  backend read data
//   err          out  1   one-cycle pulse on timeout or misaligned store
// BEHAVIOUR
//   - Reset: FSM=IDLE; every output 0; timeout counter 0; owner=NONE.
//   - FSM IDLE->REQ->WAIT->RESP->IDLE. Requests are sampled only in IDLE.
//   - Priority in IDLE: dmem_wen > dmem_ren > imem_ren. Losers stay pending, with no
//     starvation guard: the core never overlaps fetch and memory access.
//   - The owner's address/data/wlen are latched on leaving IDLE. Later input changes
//     are ignored.
//   - REQ: hold mem_req=1 with stable fields until mem_ready. Then go to WAIT;
//     mem_req drops in the same edge.
//   - WAIT: on mem_rvalid, capture mem_rdata and go to RESP.
//     A mem_rvalid seen in IDLE or REQ is ignored.
//   - RESP: exactly one of imem_rvalid/dmem_rvalid/dmem_wready is 1 for this single
//     cycle. rdata holds the last captured value until the next response.
//   - Minimum latency with mem_ready=1 and 1-cycle backend: request in IDLE @N,
//     response pulse @N+3.
//   - A requester drops ren/wen in the cycle after its pulse. A level still high in
//     the IDLE cycle after RESP is treated as a new request.
//   - Strobes from wlen/addr[1:0]:
//       len1 -> 4'b0001<<a
//       len2 -> 4'b0011<<a
//       len4 -> 4'b1111
//   - Misaligned store (a+len>4, or len not in {1,2,4}): no backend request. err=1
//     and dmem_wready=1 in RESP, one cycle after IDLE.
//   - Timeout: counter clears on entering REQ and counts in REQ and WAIT.
//     At TIMEOUT-1: drop mem_req, go to RESP, pulse err, return ERR_RDATA.
//     A late mem_rvalid is then ignored.
//   - Reset mid-access: immediate IDLE, no pulse. A pending backend response is
//     dropped by the rule above.
// CONFIGURATION
//   MEM_ARB_RAND_DELAY_EN defined: state DLY between IDLE and REQ. It waits
//     lfsr[1:0] cycles (0..3) before REQ. The 8-bit Fibonacci LFSR (taps 8,6,5,4)
//     advances every cycle from LFSR_SEED. The timeout counter does not count in DLY.
//   Undefined: no DLY state, no LFSR; IDLE goes directly to REQ.
// STRUCTURE
//   Package ysyx_25040109_mem_pkg: FSM state enum, owner enum {NONE,IF,LD,ST},
//     wlen/strobe constants.
//   Sub-module ysyx_25040109_lfsr8 (clk, rst, en, q[7:0]) is instantiated only
//     under the macro.
// TESTING
//   1 imem_ren=1, addr 0x80000004, backend ready=1, rdata 0x00100073 @+1
//     -> imem_rvalid pulse @N+3, imem_rdata=0x00100073, mem_addr=0x80000004.
//   2 dmem_wen and imem_ren both 1 @N -> store served first, dmem_wready pulse.
//     Fetch is served next, with imem_rvalid exactly 3 cycles after the IDLE re-entry.
//   3 Store wlen=1 at 0x80001003, wdata 0xAB -> wstrb=4'b1000, mem_wdata=0xAB000000.
//     wlen=2 at 0x80001003 -> err=1, dmem_wready=1, mem_req never asserted.
//   4 mem_ready=1, mem_rvalid held 0 -> err and imem_rvalid pulse at TIMEOUT-1
//     cycles after REQ entry, rdata=0xDEADBEEF.
//   5 rst low during WAIT, backend rvalid arrives 2 cycles after rst high
//     -> no response pulse, FSM stays IDLE.
//   6 With MEM_ARB_RAND_DELAY_EN: 1000 back-to-back fetches give correct data.
//     Observed latency spans 3..6 cycles.

Source files
------------

// File: rtl/ysyx_25040109_mem_pkg.sv
// ysyx_25040109_mem_pkg: shared FSM/owner types and store-strobe helpers
// for the fetch/load/store memory arbiter.
package ysyx_25040109_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DLY,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LD,
        OWN_ST
    } owner_e;

    localparam logic [2:0] WLEN_B = 3'd1;
    localparam logic [2:0] WLEN_H = 3'd2;
    localparam logic [2:0] WLEN_W = 3'd4;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic [3:0] f_wstrb(input logic [2:0] len,
                                           input logic [1:0] a);
        logic [3:0] s;
        case (len)
            WLEN_B:  s = STRB_B << a;
            WLEN_H:  s = STRB_H << a;
            WLEN_W:  s = STRB_W;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // A store is illegal if it crosses the word or has an unsupported length.
    function automatic logic f_misalign(input logic [2:0] len,
                                        input logic [1:0] a);
        logic bad;
        case (len)
            WLEN_B:  bad = 1'b0;
            WLEN_H:  bad = (a == 2'd3);
            WLEN_W:  bad = (a != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25040109_mem_arb_lfsr8.sv
// ysyx_25040109_lfsr8: 8-bit Fibonacci LFSR, taps 8,6,5,4.
// Drives the optional random request delay of the memory arbiter.
module ysyx_25040109_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/ysyx_25040109_mem_arb.sv
// ysyx_25040109_mem_arb: merges fetch, load and store channels onto one backend bus.
// Define MEM_ARB_RAND_DELAY_EN to insert an LFSR-driven 0..3 cycle delay before REQ.
module ysyx_25040109_mem_arb
    import ysyx_25040109_mem_pkg::*;
#(
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic        imem_ren,
    output logic [31:0] imem_rdata,
    output logic        imem_rvalid,
    input  logic [31:0] dmem_raddr,
    input  logic        dmem_ren,
    output logic [31:0] dmem_rdata,
    output logic        dmem_rvalid,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [2:0]  dmem_wlen,
    input  logic        dmem_wen,
    output logic        dmem_wready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e         r_state;
    owner_e         r_owner;
    logic [CW-1:0]  r_cnt;

    owner_e         w_owner;
    logic [31:0]    w_addr;
    logic [31:0]    w_wdata;
    logic [3:0]     w_wstrb;
    logic           w_bad;
    logic           w_tmo;
    logic           w_ok;
    logic           w_fin;
    logic [31:0]    w_data;

`ifdef MEM_ARB_RAND_DELAY_EN
    logic [7:0]     w_lfsr;
    logic [1:0]     r_dly;

    ysyx_25040109_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (w_lfsr)
    );
`else
    logic [7:0]     w_unused_seed;
    assign w_unused_seed = LFSR_SEED;
`endif

    always_comb begin
        w_owner = OWN_NONE;
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        w_bad   = 1'b0;
        if (dmem_wen) begin
            w_owner = OWN_ST;
            w_addr  = {dmem_waddr[31:2], 2'b00};
            w_wdata = dmem_wdata << {dmem_waddr[1:0], 3'b000};
            w_wstrb = f_wstrb(dmem_wlen, dmem_waddr[1:0]);
            w_bad   = f_misalign(dmem_wlen, dmem_waddr[1:0]);
        end else if (dmem_ren) begin
            w_owner = OWN_LD;
            w_addr  = {dmem_raddr[31:2], 2'b00};
        end else if (imem_ren) begin
            w_owner = OWN_IF;
            w_addr  = {imem_addr[31:2], 2'b00};
        end
    end

    // Abort fires so the response lands TIMEOUT-1 cycles after REQ entry.
    assign w_tmo  = (r_cnt >= CW'(TIMEOUT - 2));
    assign w_ok   = (r_state == ST_WAIT) && mem_rvalid;
    assign w_fin  = w_ok
                 || ((r_state == ST_WAIT) && w_tmo)
                 || ((r_state == ST_REQ) && !mem_ready && w_tmo);
    assign w_data = w_ok ? mem_rdata : ERR_RDATA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_NONE;
            r_cnt       <= '0;
`ifdef MEM_ARB_RAND_DELAY_EN
            r_dly       <= '0;
`endif
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            imem_rdata  <= '0;
            imem_rvalid <= 1'b0;
            dmem_rdata  <= '0;
            dmem_rvalid <= 1'b0;
            dmem_wready <= 1'b0;
            err         <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            dmem_rvalid <= 1'b0;
            dmem_wready <= 1'b0;
            err         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_owner != OWN_NONE) begin
                        r_owner <= w_owner;
                        if (w_bad) begin
                            r_state     <= ST_RESP;
                            err         <= 1'b1;
                            dmem_wready <= 1'b1;
                        end else begin
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                            mem_wstrb <= w_wstrb;
`ifdef MEM_ARB_RAND_DELAY_EN
                            if (w_lfsr[1:0] == 2'd0) begin
                                r_state <= ST_REQ;
                                mem_req <= 1'b1;
                                mem_we  <= (w_owner == OWN_ST);
                            end else begin
                                r_state <= ST_DLY;
                                r_dly   <= w_lfsr[1:0] - 2'd1;
                            end
`else
                            r_state <= ST_REQ;
                            mem_req <= 1'b1;
                            mem_we  <= (w_owner == OWN_ST);
`endif
                        end
                    end
                end
`ifdef MEM_ARB_RAND_DELAY_EN
                ST_DLY: begin
                    if (r_dly == 2'd0) begin
                        r_state <= ST_REQ;
                        r_cnt   <= '0;
                        mem_req <= 1'b1;
                        mem_we  <= (r_owner == OWN_ST);
                    end else begin
                        r_dly <= r_dly - 2'd1;
                    end
                end
`endif
                ST_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ready || w_tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                    if (mem_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_owner <= OWN_NONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_fin) begin
                r_state <= ST_RESP;
                err     <= !w_ok;
                case (r_owner)
                    OWN_IF: begin
                        imem_rvalid <= 1'b1;
                        imem_rdata  <= w_data;
                    end
                    OWN_LD: begin
                        dmem_rvalid <= 1'b1;
                        dmem_rdata  <= w_data;
                    end
                    OWN_ST:  dmem_wready <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_mem_arb.sv
// tb_ysyx_25040109_mem_arb: directed vector table plus hand-written
// sequences for arbitration, timeout and reset corner cases.
module tb_ysyx_25040109_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        imem_ren = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] dmem_raddr = '0;
    logic        dmem_ren = 1'b0;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_waddr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [2:0]  dmem_wlen = '0;
    logic        dmem_wen = 1'b0;
    logic        dmem_wready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    always #5 clk = ~clk;

    ysyx_25040109_mem_arb dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .dmem_raddr  (dmem_raddr),
        .dmem_ren    (dmem_ren),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wlen   (dmem_wlen),
        .dmem_wen    (dmem_wen),
        .dmem_wready (dmem_wready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .err         (err)
    );

    int n_chk = 0;
    int n_fail = 0;

    bit          be_pend = 1'b0;
    bit          be_auto = 1'b1;
    bit          be_force = 1'b0;
    logic [31:0] be_data = '0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  wlen;
        logic [31:0] bdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        bit          e_err;
        int          e_lat;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Backend: answers one cycle after each mem_req&&mem_ready handshake.
    task automatic tick();
        @(negedge clk);
        mem_rdata  = be_data;
        mem_rvalid = (be_pend && be_auto) || be_force;
        be_pend    = mem_req && mem_ready;
    endtask

    function automatic vec_t mk(input string n, input int k,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] wl, input logic [31:0] bd,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] es, input bit ee,
                                input int el);
        vec_t v;
        v.name = n; v.kind = k; v.addr = a; v.wdata = wd; v.wlen = wl;
        v.bdata = bd; v.e_addr = ea; v.e_wdata = ew; v.e_strb = es;
        v.e_err = ee; v.e_lat = el;
        return v;
    endfunction

    task automatic drop_all();
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        bit          seen;
        bit          done;
        logic [2:0]  pul;
        logic [2:0]  e_pul;
        logic        ev;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [3:0]  s;
        lat = 0; seen = 0; done = 0; pul = '0; ev = 0; we = 0;
        a = '0; d = '0; rd = '0; s = '0;
        be_data = v.bdata;
        case (v.kind)
            0: begin imem_addr = v.addr; imem_ren = 1'b1; e_pul = 3'b100; end
            1: begin dmem_raddr = v.addr; dmem_ren = 1'b1; e_pul = 3'b010; end
            default: begin
                dmem_waddr = v.addr; dmem_wdata = v.wdata;
                dmem_wlen = v.wlen; dmem_wen = 1'b1; e_pul = 3'b001;
            end
        endcase
        for (int c = 1; c <= 20 && !done; c++) begin
            tick();
            if (mem_req && !seen) begin
                seen = 1; a = mem_addr; d = mem_wdata; s = mem_wstrb; we = mem_we;
            end
            if (imem_rvalid || dmem_rvalid || dmem_wready) begin
                done = 1; lat = c; ev = err;
                pul = {imem_rvalid, dmem_rvalid, dmem_wready};
                rd = imem_rvalid ? imem_rdata : dmem_rdata;
                drop_all();
            end
        end
        tick();
        chk({v.name, " one-cycle pulse"},
            {28'd0, imem_rvalid, dmem_rvalid, dmem_wready, err}, 32'd0);
`ifdef MEM_ARB_RAND_DELAY_EN
        chk({v.name, " latency in range"},
            32'(lat >= v.e_lat && lat <= v.e_lat + (v.e_err ? 0 : 3)), 32'd1);
`else
        chk({v.name, " latency"}, lat, v.e_lat);
`endif
        chk({v.name, " pulse"}, pul, e_pul);
        chk({v.name, " err"}, ev, v.e_err);
        chk({v.name, " mem_req seen"}, seen, !v.e_err);
        if (!v.e_err) begin
            chk({v.name, " mem_addr"}, a, v.e_addr);
            chk({v.name, " mem_we"}, we, v.kind == 2);
            if (v.kind == 2) begin
                chk({v.name, " mem_wdata"}, d, v.e_wdata);
                chk({v.name, " mem_wstrb"}, s, v.e_strb);
            end else begin
                chk({v.name, " rdata"}, rd, v.bdata);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_a;
        int          t_b;
        int          n_hi;
        bit          seen;
        logic        lv;
        logic [31:0] rd;

        vt[0]  = mk("if0",    0, 32'h80000004, 32'h0,        3'd0, 32'h00100073,
                    32'h80000004, 32'h0,        4'h0, 0, 3);
        vt[1]  = mk("ld0",    1, 32'h80000010, 32'h0,        3'd0, 32'h12345678,
                    32'h80000010, 32'h0,        4'h0, 0, 3);
        vt[2]  = mk("ld_un",  1, 32'h80000013, 32'h0,        3'd0, 32'hA5A55A5A,
                    32'h80000010, 32'h0,        4'h0, 0, 3);
        vt[3]  = mk("st_b3",  2, 32'h80001003, 32'h000000AB, 3'd1, 32'h0,
                    32'h80001000, 32'hAB000000, 4'h8, 0, 3);
        vt[4]  = mk("st_h2",  2, 32'h80001002, 32'h00001234, 3'd2, 32'h0,
                    32'h80001000, 32'h12340000, 4'hC, 0, 3);
        vt[5]  = mk("st_w0",  2, 32'h80001000, 32'hCAFEF00D, 3'd4, 32'h0,
                    32'h80001000, 32'hCAFEF00D, 4'hF, 0, 3);
        vt[6]  = mk("st_b1",  2, 32'h80001001, 32'hFFFFFF5A, 3'd1, 32'h0,
                    32'h80001000, 32'hFFFF5A00, 4'h2, 0, 3);
        vt[7]  = mk("st_h0",  2, 32'h80001000, 32'h0000BEEF, 3'd2, 32'h0,
                    32'h80001000, 32'h0000BEEF, 4'h3, 0, 3);
        vt[8]  = mk("mis_h3", 2, 32'h80001003, 32'h0000ABCD, 3'd2, 32'h0,
                    32'h0,        32'h0,        4'h0, 1, 1);
        vt[9]  = mk("mis_w2", 2, 32'h80001002, 32'h01020304, 3'd4, 32'h0,
                    32'h0,        32'h0,        4'h0, 1, 1);
        vt[10] = mk("bad_l3", 2, 32'h80001000, 32'h01020304, 3'd3, 32'h0,
                    32'h0,        32'h0,        4'h0, 1, 1);
        vt[11] = mk("if1",    0, 32'h80000008, 32'h0,        3'd0, 32'h00000013,
                    32'h80000008, 32'h0,        4'h0, 0, 3);

        // Reset state
        tick(); tick();
        chk("reset ctl", {21'd0, mem_req, mem_we, mem_wstrb,
                          imem_rvalid, dmem_rvalid, dmem_wready, err}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset imem_rdata", imem_rdata, 32'd0);
        chk("reset dmem_rdata", dmem_rdata, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i]);
        end

        // Store and fetch together: store wins, fetch follows
        dmem_waddr = 32'h80002000; dmem_wdata = 32'h11223344;
        dmem_wlen = 3'd4; dmem_wen = 1'b1;
        imem_addr = 32'h80000100; imem_ren = 1'b1;
        be_data = 32'h00000013;
        t_a = 0; t_b = 0; seen = 0; lv = 0; rd = '0;
        for (int c = 1; c <= 30 && t_b == 0; c++) begin
            tick();
            if (mem_req && !seen) begin seen = 1; lv = mem_we; end
            if (dmem_wready && t_a == 0) begin t_a = c; dmem_wen = 1'b0; end
            if (imem_rvalid) begin t_b = c; rd = imem_rdata; imem_ren = 1'b0; end
        end
        chk("arb store first", lv, 1'b1);
`ifdef MEM_ARB_RAND_DELAY_EN
        chk("arb order", 32'(t_a > 0 && t_b > t_a), 32'd1);
`else
        chk("arb store pulse", t_a, 3);
        chk("arb fetch pulse", t_b, 7);
`endif
        chk("arb fetch data", rd, 32'h00000013);
        tick();

        // Timeout in WAIT, then a late backend response
        be_auto = 1'b0;
        imem_addr = 32'h80000200; imem_ren = 1'b1;
        t_a = 0; t_b = 0; lv = 0; rd = '0;
        for (int c = 1; c <= 400 && t_b == 0; c++) begin
            tick();
            if (mem_req && t_a == 0) t_a = c;
            if (imem_rvalid) begin
                t_b = c; lv = err; rd = imem_rdata; imem_ren = 1'b0;
            end
        end
        chk("tmo wait latency", t_b - t_a, 255);
        chk("tmo wait err", lv, 1'b1);
        chk("tmo wait rdata", rd, 32'hDEADBEEF);
        tick();
        be_force = 1'b1; tick(); be_force = 1'b0;
        n_hi = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_hi += int'(imem_rvalid | dmem_rvalid | dmem_wready | err | mem_req);
        end
        chk("tmo late rvalid ignored", n_hi, 0);

        // Timeout in REQ with backend never ready
        mem_ready = 1'b0;
        dmem_raddr = 32'h80000400; dmem_ren = 1'b1;
        t_a = 0; t_b = 0; n_hi = 0; lv = 1; rd = '0;
        for (int c = 1; c <= 400 && t_b == 0; c++) begin
            tick();
            if (mem_req && t_a == 0) t_a = c;
            if (dmem_rvalid) begin
                t_b = c; lv = mem_req; rd = dmem_rdata; dmem_ren = 1'b0;
            end else if (mem_req) begin
                n_hi++;
            end
        end
        chk("tmo req latency", t_b - t_a, 255);
        chk("tmo req held cycles", n_hi, 255);
        chk("tmo req dropped", lv, 1'b0);
        chk("tmo req rdata", rd, 32'hDEADBEEF);
        mem_ready = 1'b1;
        tick();

        // Reset while waiting on the backend
        imem_addr = 32'h80000300; imem_ren = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = be_pend;
        end
        tick();
        chk("rst-mid handshake", seen, 1'b1);
        rst = 1'b0; imem_ren = 1'b0;
        #1;
        chk("rst-mid outputs", {27'd0, mem_req, imem_rvalid, dmem_rvalid,
                                dmem_wready, err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        be_force = 1'b1; tick(); be_force = 1'b0;
        n_hi = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_hi += int'(imem_rvalid | dmem_rvalid | dmem_wready | err | mem_req);
        end
        chk("rst-mid no pulse", n_hi, 0);
        be_auto = 1'b1;
        be_pend = 1'b0;
        run_vec(vt[0]);

`ifdef MEM_ARB_RAND_DELAY_EN
        // Back-to-back fetches under random delay
        t_a = 99; t_b = 0; n_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            int lat;
            lat = 0;
            be_data = 32'h10000000 + 32'(i * 7);
            imem_addr = 32'h80000000 + 32'(i * 4); imem_ren = 1'b1;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                tick();
                if (imem_rvalid) begin
                    lat = c; imem_ren = 1'b0;
                    if (imem_rdata !== be_data) n_hi++;
                end
            end
            if (lat < t_a) t_a = lat;
            if (lat > t_b) t_b = lat;
            tick();
        end
        chk("rand data errors", n_hi, 0);
        chk("rand min latency", t_a, 3);
        chk("rand max latency", t_b, 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
